// File: rtl/tdm_demux1_4.sv
// tdm_demux1_4 -- 1-to-4 time-division demultiplexer.
// A frame is four valid beats; the beat carrying frame_sync is slot 0 and
// is routed to y0, the next three valid beats to y1..y3. Every output is
// registered, so results appear one clock after the accepting edge.
// Optional feature: define TDM_DEMUX_SYNC_CHECK_EN to flag framing
// violations on sync_err (a missing sync at slot 0 drops lock back to IDLE).
// Without it, sync_err is tied low and slot 0 free-runs.
// Handshake: a beat is any rising clk with din_valid=1; there is no
// back-pressure, and frame_sync means nothing unless din_valid is also high.
module tdm_demux1_4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [3:0]       y_valid,
   output logic             frame_done,
   output logic             sync_err,
   output logic             dbg_state,
   output logic [1:0]       dbg_slot
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t     state, next_state;
   logic [1:0] slot, next_slot;
   logic       wr_en;
   logic [1:0] wr_slot;
   logic       done;
   logic       err;

   // State register: FSM state and slot counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         slot  <= 2'd0;
      end else begin
         state <= next_state;
         slot  <= next_slot;
      end
   end

   // Next-state logic: lock on sync, advance slot on each accepted beat.
   always_comb begin
      next_state = state;
      next_slot  = slot;
      if (din_valid) begin
         if (state == IDLE) begin
            if (frame_sync) begin
               next_state = RUN;
               next_slot  = 2'd1;
            end
         end else if (frame_sync) begin
            // Sync at slot 0 is normal; anywhere else it forces a resync.
            next_slot = 2'd1;
         end else if (slot != 2'd0) begin
            next_slot = slot + 2'd1;
         end else begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            // Slot 0 arrived without sync: lock is lost.
            next_state = IDLE;
`else
            // Free-running: treat the beat as slot 0.
            next_slot = 2'd1;
`endif
         end
      end
   end

   // Output decode: which channel this beat writes and which flags fire.
   always_comb begin
      wr_en   = 1'b0;
      wr_slot = 2'd0;
      done    = 1'b0;
      err     = 1'b0;
      if (din_valid) begin
         if (state == IDLE) begin
            wr_en = frame_sync;
         end else if (frame_sync) begin
            wr_en = 1'b1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            err   = (slot != 2'd0);
`endif
         end else if (slot != 2'd0) begin
            wr_en   = 1'b1;
            wr_slot = slot;
            done    = (slot == 2'd3);
         end else begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            err   = 1'b1;
`else
            wr_en = 1'b1;
`endif
         end
      end
   end

   // Registered outputs: channel words hold until addressed, flags pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         y0         <= '0;
         y1         <= '0;
         y2         <= '0;
         y3         <= '0;
         y_valid    <= 4'b0000;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         y_valid    <= wr_en ? (4'b0001 << wr_slot) : 4'b0000;
         frame_done <= done;
         sync_err   <= err;
         if (wr_en) begin
            case (wr_slot)
               2'd0:    y0 <= din;
               2'd1:    y1 <= din;
               2'd2:    y2 <= din;
               default: y3 <= din;
            endcase
         end
      end
   end

   assign dbg_state = state;
   assign dbg_slot  = slot;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// Directed testbench for tdm_demux1_4 (WIDTH=4). Expected values are
// hand-computed; the sync-check build is selected by the same macro as the RTL.
module tb_tdm_demux1_4;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'h0;
   logic       din_valid = 1'b0;
   logic       frame_sync = 1'b0;
   logic [3:0] y0, y1, y2, y3;
   logic [3:0] y_valid;
   logic       frame_done, sync_err, dbg_state;
   logic [1:0] dbg_slot;

   int n_vec = 0;
   int n_err = 0;
   int vld_cnt;
   int done_cnt;

   // clock
   always #5 clk = ~clk;

   tdm_demux1_4 #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .frame_sync(frame_sync), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .y_valid(y_valid), .frame_done(frame_done), .sync_err(sync_err),
      .dbg_state(dbg_state), .dbg_slot(dbg_slot)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, let the edge take them, sample 1 ns later.
   task automatic step(input logic v, input logic fs, input logic [3:0] d);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      @(posedge clk);
      #1;
      vld_cnt  += (y_valid != 4'b0000) ? 1 : 0;
      done_cnt += frame_done ? 1 : 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 1'b0, 4'h0);
      rst = 1'b0;
   endtask

   task automatic check_y(input string tag, input logic [15:0] exp);
      check(tag, {y3, y2, y1, y0}, {16'h0, exp});
   endtask

   initial begin
      vld_cnt  = 0;
      done_cnt = 0;

      // reset state
      do_reset();
      check_y("rst_y", 16'h0000);
      check("rst_vld", y_valid, 4'b0000);
      check("rst_done", frame_done, 0);
      check("rst_err", sync_err, 0);
      check("rst_state", dbg_state, 0);

      // basic frame A,B,C,D
      step(1'b1, 1'b1, 4'hA);
      check("f1_vld0", y_valid, 4'b0001);
      check("f1_y0", y0, 4'hA);
      step(1'b1, 1'b0, 4'hB);
      check("f1_vld1", y_valid, 4'b0010);
      check("f1_done_early", frame_done, 0);
      step(1'b1, 1'b0, 4'hC);
      check("f1_vld2", y_valid, 4'b0100);
      step(1'b1, 1'b0, 4'hD);
      check("f1_vld3", y_valid, 4'b1000);
      check("f1_done", frame_done, 1);
      check_y("f1_y", 16'hDCBA);
      step(1'b0, 1'b0, 4'h0);
      check("f1_vld_idle", y_valid, 4'b0000);
      check("f1_done_clr", frame_done, 0);
      check_y("f1_y_hold", 16'hDCBA);

      // IDLE discards beats without sync; sync without valid is ignored
      do_reset();
      step(1'b1, 1'b0, 4'h5);
      check("idle_vld5", y_valid, 4'b0000);
      step(1'b1, 1'b0, 4'h6);
      check("idle_vld6", y_valid, 4'b0000);
      check_y("idle_y", 16'h0000);
      step(1'b0, 1'b1, 4'hF);
      check("idle_fs_novalid", y_valid, 4'b0000);
      check("idle_state", dbg_state, 0);

      // frame with 2 idle cycles between beats
      do_reset();
      vld_cnt  = 0;
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, (i == 0), 4'(i + 1));
         if (i < 3) begin
            step(1'b0, 1'b0, 4'hF);
            step(1'b0, 1'b1, 4'hF);
         end
      end
      step(1'b0, 1'b0, 4'h0);
      check_y("gap_y", 16'h4321);
      check("gap_vld_cnt", vld_cnt, 4);
      check("gap_done_cnt", done_cnt, 1);

      // slot-0 beat without sync after a full frame (state RUN, slot 0)
      step(1'b1, 1'b0, 4'hE);
      check("nosync_err", sync_err, CHK);
      check("nosync_vld", y_valid, CHK ? 4'b0000 : 4'b0001);
      check_y("nosync_y", CHK ? 16'h4321 : 16'h432E);
      check("nosync_state", dbg_state, CHK ? 0 : 1);

      // sync in the middle of a frame forces a resync
      do_reset();
      step(1'b1, 1'b1, 4'h1);
      step(1'b1, 1'b0, 4'h2);
      step(1'b1, 1'b1, 4'h9);
      check("resync_err", sync_err, CHK);
      check("resync_vld", y_valid, 4'b0001);
      check("resync_done", frame_done, 0);
      check("resync_y0", y0, 4'h9);
      check("resync_y1", y1, 4'h2);
      step(1'b1, 1'b0, 4'h7);
      check("resync_err_clr", sync_err, 0);
      step(1'b1, 1'b0, 4'h8);
      step(1'b1, 1'b0, 4'h6);
      check("resync_done2", frame_done, 1);
      check_y("resync_y", 16'h6879);

      // reset mid-frame (slot 2) wins over a simultaneous beat
      do_reset();
      step(1'b1, 1'b1, 4'h1);
      step(1'b1, 1'b0, 4'h2);
      check("midrst_slot", dbg_slot, 2);
      rst = 1'b1;
      step(1'b1, 1'b0, 4'h3);
      rst = 1'b0;
      check_y("midrst_y", 16'h0000);
      check("midrst_vld", y_valid, 4'b0000);
      check("midrst_done", frame_done, 0);
      step(1'b1, 1'b0, 4'h4);
      check("midrst_ignore_vld", y_valid, 4'b0000);
      check_y("midrst_ignore_y", 16'h0000);
      check("midrst_state", dbg_state, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
